jelly2_necolink_packet_scheduler: RTL and testbench
===================================================

JELLY2_NECOLINK_PACKET_SCHEDULER -- requirements
Module: jelly2_necolink_packet_scheduler

Interface
REQ-001 Parameter N, default 4: number of packet requesters, range 2..16.
REQ-002 Parameter GAP_CYCLES, default 12: enabled (cke=1) cycles of idle inserted after each packet finish; 0 is allowed.
REQ-003 Parameter TIMEOUT_CYCLES, default 4096: WAIT_FINISH watchdog limit, used only when the Configuration macro is defined.
REQ-004 reset_n  in  1  asynchronous active-low reset.
REQ-005 clk  in  1  single clock, rising edge.
REQ-006 cke  in  1  clock enable; all state advances only when cke=1.
REQ-007 s_req  in  N  per-requester request; held high until the matching s_ack.
REQ-008 s_mac_enable  in  N  per-requester param_mac_enable.
REQ-009 s_node, s_type  in  N x 8  per-requester node and type bytes.
REQ-010 s_length  in  N x 16  per-requester payload length.
REQ-011 s_ack  out  N  one-hot, one-cycle pulse when that requester's packet is accepted by the generator.
REQ-012 s_done  out  N  one-hot, one-cycle pulse when that requester's packet finishes.
REQ-013 gen_start  out  1  start request to the packet generator.
REQ-014 gen_mac_enable, gen_node, gen_type, gen_length  out  1/8/8/16  latched parameters of the granted requester.
REQ-015 gen_busy, gen_finish  in  1/1  generator busy level and packet_finish pulse.
REQ-016 busy  out  1  high in every state except IDLE.
REQ-017 grant_index  out  4  index of the current or last granted requester.
REQ-018 timeout_error  out  1  sticky watchdog flag.

Function
REQ-019 States: IDLE, START, WAIT_FINISH, GAP.
REQ-020 IDLE, any s_req bit high:
  - round-robin selection, starting from (last grant + 1) mod N;
  - latch grant_index and the gen_* parameters from the selected requester;
  - next state START.
REQ-021 START:
  - gen_start=1, held until gen_busy=1 is sampled;
  - on that cycle: gen_start=0, s_ack[grant] pulses, next state WAIT_FINISH;
  - gen_start lasts at least 1 cycle and is unbounded while the generator is back-pressured.
REQ-022 WAIT_FINISH, on gen_finish:
  - s_done[grant] pulses;
  - GAP_CYCLES>0: next state GAP, gap counter loaded with GAP_CYCLES-1;
  - GAP_CYCLES=0: next state IDLE.
REQ-023 GAP: counter decrements each cke cycle; at 0, next state IDLE; requests are not evaluated during GAP.
REQ-024 Round-robin pointer: updates only on grant; the just-granted requester has lowest priority at the next arbitration.
REQ-025 A requester that drops s_req before s_ack: the grant is still honoured with the latched parameters; s_ack and s_done still pulse.
REQ-026 gen_* parameters stay stable from grant until the next grant.
REQ-027 cke=0: all registers hold, and s_ack, s_done and gen_start hold their values.
REQ-028 Single outstanding packet: a new grant never occurs before returning to IDLE.

Reset
REQ-029 reset_n=0 forces, asynchronously:
  - state=IDLE; RR pointer so that requester 0 has highest priority;
  - gen_start=0, gen_* params=0, s_ack=0, s_done=0, busy=0, grant_index=0, timeout_error=0.
REQ-030 Reset mid-packet abandons the grant; no s_done is issued for it.

Configuration
REQ-031 Macro JELLY2_NECOLINK_SCHEDULER_TIMEOUT_EN.
  - Defined: a WAIT_FINISH counter runs. If TIMEOUT_CYCLES cke cycles pass without gen_finish, timeout_error is set and the block proceeds exactly as if gen_finish had arrived (s_done pulse, then GAP).
  - Undefined: no counter; timeout_error is tied to 0; the block waits for gen_finish indefinitely.

Structure
REQ-032 Package jelly2_necolink_pkg holds the t_sched_state enum (one-hot encoding) and the default constants GAP_CYCLES=12 and TIMEOUT_CYCLES=4096.
REQ-033 Round-robin selection lives in sub-module jelly2_necolink_rr_arbiter (combinational: req vector + pointer -> one-hot grant + valid).

Verification
REQ-034 Single request, s_req=0001, gen_busy rising 2 cycles after gen_start -> gen_start high exactly 2 cycles, then s_ack=0001, gen_node=s_node[0].
REQ-035 s_req=1111 held continuously -> grants in order 0,1,2,3,0; each s_done precedes the next s_ack by at least 12 cycles.
REQ-036 GAP_CYCLES=0, back-to-back requests -> IDLE re-entered the cycle after s_done; next gen_start follows 1 cycle later.
REQ-037 reset_n low during WAIT_FINISH of requester 2 -> all outputs 0 immediately; no s_done; first grant after reset is the lowest-index active requester.
REQ-038 Macro defined, TIMEOUT_CYCLES=16, gen_finish never asserted -> timeout_error=1 after 16 cycles, s_done pulses, scheduler returns to IDLE after the gap.
REQ-039 cke toggling 50% during a full packet -> same event sequence as with cke=1; all pulses stretched over the cke=0 cycles.

Source files
------------

// File: rtl/jelly2_necolink_pkg.sv
// Shared types and defaults for the NecoLink packet scheduler: one-hot FSM state
// encoding, default timing constants and a one-hot to index helper.
package jelly2_necolink_pkg;

    typedef enum logic [3:0] {
        ST_IDLE        = 4'b0001,
        ST_START       = 4'b0010,
        ST_WAIT_FINISH = 4'b0100,
        ST_GAP         = 4'b1000
    } t_sched_state;

    localparam int GAP_CYCLES     = 12;
    localparam int TIMEOUT_CYCLES = 4096;

    function automatic logic [3:0] onehot_to_index(input logic [15:0] onehot);
        onehot_to_index = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            if (onehot[i]) begin
                onehot_to_index = 4'(i);
            end
        end
    endfunction

endpackage

// File: rtl/jelly2_necolink_rr_arbiter.sv
// Combinational round-robin arbiter: ptr names the requester with highest
// priority; returns a one-hot grant and a valid flag.
module jelly2_necolink_rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0] req,
    input  logic [3:0]   ptr,
    output logic [N-1:0] grant,
    output logic         valid
);

    logic [N-1:0]   rot;
    logic [N-1:0]   oh;
    logic [2*N-1:0] back;

    // rotate so ptr sits at bit 0, pick the lowest set bit, rotate back
    always_comb begin
        rot   = N'({req, req} >> ptr);
        oh    = '0;
        valid = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (rot[i] && !valid) begin
                oh[i] = 1'b1;
                valid = 1'b1;
            end
        end
        back  = {{N{1'b0}}, oh} << ptr;
        grant = back[N-1:0] | back[2*N-1:N];
    end

endmodule

// File: rtl/jelly2_necolink_packet_scheduler.sv
// Round-robin scheduler handing one packet at a time to the NecoLink generator.
// Optional WAIT_FINISH watchdog: define JELLY2_NECOLINK_SCHEDULER_TIMEOUT_EN.
module jelly2_necolink_packet_scheduler #(
    parameter int N              = 4,
    parameter int GAP_CYCLES     = jelly2_necolink_pkg::GAP_CYCLES,
    parameter int TIMEOUT_CYCLES = jelly2_necolink_pkg::TIMEOUT_CYCLES
) (
    input  logic            reset_n,
    input  logic            clk,
    input  logic            cke,

    input  logic [N-1:0]    s_req,
    input  logic [N-1:0]    s_mac_enable,
    input  logic [N*8-1:0]  s_node,
    input  logic [N*8-1:0]  s_type,
    input  logic [N*16-1:0] s_length,
    output logic [N-1:0]    s_ack,
    output logic [N-1:0]    s_done,

    output logic            gen_start,
    output logic            gen_mac_enable,
    output logic [7:0]      gen_node,
    output logic [7:0]      gen_type,
    output logic [15:0]     gen_length,
    input  logic            gen_busy,
    input  logic            gen_finish,

    output logic            busy,
    output logic [3:0]      grant_index,
    output logic            timeout_error
);

    import jelly2_necolink_pkg::*;

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    t_sched_state   state;
    logic [3:0]     rr_ptr;
    logic [GAP_W-1:0] gap_cnt;

    logic [N-1:0]   arb_grant;
    logic           arb_valid;
    logic [3:0]     arb_index;
    logic [N-1:0]   grant_onehot;
    logic           finish_evt;

    logic           sel_mac_enable;
    logic [7:0]     sel_node;
    logic [7:0]     sel_type;
    logic [15:0]    sel_length;

    jelly2_necolink_rr_arbiter #(
        .N(N)
    ) u_rr_arbiter (
        .req   (s_req),
        .ptr   (rr_ptr),
        .grant (arb_grant),
        .valid (arb_valid)
    );

    assign arb_index    = onehot_to_index(16'(arb_grant));
    assign grant_onehot = N'(1) << grant_index;
    assign busy         = (state != ST_IDLE);

    always_comb begin
        sel_mac_enable = 1'b0;
        sel_node       = '0;
        sel_type       = '0;
        sel_length     = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (arb_grant[i]) begin
                sel_mac_enable = s_mac_enable[i];
                sel_node       = s_node[i*8 +: 8];
                sel_type       = s_type[i*8 +: 8];
                sel_length     = s_length[i*16 +: 16];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= ST_IDLE;
            rr_ptr         <= '0;
            gap_cnt        <= '0;
            grant_index    <= '0;
            gen_start      <= 1'b0;
            gen_mac_enable <= 1'b0;
            gen_node       <= '0;
            gen_type       <= '0;
            gen_length     <= '0;
            s_ack          <= '0;
            s_done         <= '0;
        end else if (cke) begin
            s_ack  <= '0;
            s_done <= '0;
            case (state)
                ST_IDLE: begin
                    if (arb_valid) begin
                        grant_index    <= arb_index;
                        gen_mac_enable <= sel_mac_enable;
                        gen_node       <= sel_node;
                        gen_type       <= sel_type;
                        gen_length     <= sel_length;
                        rr_ptr         <= (arb_index == 4'(N - 1)) ? 4'd0 : arb_index + 4'd1;
                        gen_start      <= 1'b1;
                        state          <= ST_START;
                    end
                end
                ST_START: begin
                    if (gen_busy) begin
                        gen_start <= 1'b0;
                        s_ack     <= grant_onehot;
                        state     <= ST_WAIT_FINISH;
                    end
                end
                ST_WAIT_FINISH: begin
                    if (finish_evt) begin
                        s_done <= grant_onehot;
                        if (GAP_CYCLES > 0) begin
                            gap_cnt <= GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
                            state   <= ST_GAP;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == '0) begin
                        state <= ST_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef JELLY2_NECOLINK_SCHEDULER_TIMEOUT_EN
    localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [WD_W-1:0] wd_cnt;
    logic            wd_expire;

    assign wd_expire  = (state == ST_WAIT_FINISH) && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
    assign finish_evt = gen_finish || wd_expire;

    // counter is held at zero outside WAIT_FINISH so each packet starts fresh
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wd_cnt        <= '0;
            timeout_error <= 1'b0;
        end else if (cke) begin
            if (state == ST_WAIT_FINISH && !gen_finish && !wd_expire) begin
                wd_cnt <= wd_cnt + 1'b1;
            end else begin
                wd_cnt <= '0;
            end
            if (wd_expire && !gen_finish) begin
                timeout_error <= 1'b1;
            end
        end
    end
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign finish_evt         = gen_finish;
    assign timeout_error      = 1'b0;
`endif

endmodule

// File: tb/tb_jelly2_necolink_packet_scheduler.sv
// Randomized bench for jelly2_necolink_packet_scheduler with a transaction-level
// round-robin model and a behavioural packet-generator responder.
module tb_jelly2_necolink_packet_scheduler;

    localparam int N          = 4;
    localparam int TB_GAP     = 12;
    localparam int TB_TIMEOUT = 16;

    logic            reset_n;
    logic            clk;
    logic            cke;
    logic [N-1:0]    s_req;
    logic [N-1:0]    s_mac_enable;
    logic [N*8-1:0]  s_node;
    logic [N*8-1:0]  s_type;
    logic [N*16-1:0] s_length;
    logic [N-1:0]    s_ack;
    logic [N-1:0]    s_done;
    logic            gen_start;
    logic            gen_mac_enable;
    logic [7:0]      gen_node;
    logic [7:0]      gen_type;
    logic [15:0]     gen_length;
    logic            gen_busy;
    logic            gen_finish;
    logic            busy;
    logic [3:0]      grant_index;
    logic            timeout_error;

    jelly2_necolink_packet_scheduler #(
        .N              (N),
        .GAP_CYCLES     (TB_GAP),
        .TIMEOUT_CYCLES (TB_TIMEOUT)
    ) u_dut (
        .reset_n        (reset_n),
        .clk            (clk),
        .cke            (cke),
        .s_req          (s_req),
        .s_mac_enable   (s_mac_enable),
        .s_node         (s_node),
        .s_type         (s_type),
        .s_length       (s_length),
        .s_ack          (s_ack),
        .s_done         (s_done),
        .gen_start      (gen_start),
        .gen_mac_enable (gen_mac_enable),
        .gen_node       (gen_node),
        .gen_type       (gen_type),
        .gen_length     (gen_length),
        .gen_busy       (gen_busy),
        .gen_finish     (gen_finish),
        .busy           (busy),
        .grant_index    (grant_index),
        .timeout_error  (timeout_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit en;
    bit cke_rand;
    int req_mode;
    int m_last;
    bit m_timeout;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic tick();
        cke = cke_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        en  = cke;
        @(posedge clk);
        #1;
    endtask

    function automatic int rr_pick(input logic [N-1:0] r, input int last);
        for (int i = 1; i <= N; i++) begin
            int c;
            c = (last + i) % N;
            if (r[c]) return c;
        end
        return -1;
    endfunction

    task automatic scramble_params();
        for (int i = 0; i < N; i++) begin
            s_mac_enable[i]    = 1'($urandom_range(0, 1));
            s_node[i*8 +: 8]   = 8'($urandom);
            s_type[i*8 +: 8]   = 8'($urandom);
            s_length[i*16 +: 16] = 16'($urandom);
        end
    endtask

    task automatic next_requests();
        logic [N-1:0] r;
        case (req_mode)
            0: s_req = '1;
            1: begin
                r = N'($urandom);
                if (r == '0) r[$urandom_range(0, N-1)] = 1'b1;
                s_req = r;
            end
            default: s_req = '0;
        endcase
    endtask

    task automatic wait_start(input bit after_done, output bit found);
        int n;
        bit chk;
        n = 0;
        chk = 1'b0;
        found = 1'b0;
        for (int t = 0; t < 500; t++) begin
            tick();
            if (en) begin
                n++;
                if (after_done && n == 1) check_eq("done_pulse", s_done, '0);
            end
            if (after_done && !chk && n == TB_GAP) begin
                check_eq("gap_idle", busy, 1'b0);
                chk = 1'b1;
            end
            if (gen_start) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) begin
            check_eq("start_timeout", 0, 1);
        end else if (after_done) begin
            check_eq("gap_len", n, TB_GAP + 1);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        for (int t = 0; t < 500 && n < TB_GAP; t++) begin
            tick();
            if (en) begin
                n++;
                if (n == 1) check_eq("done_pulse", s_done, '0);
            end
        end
        check_eq("idle_busy", busy, 1'b0);
        for (int t = 0; t < 5; t++) tick();
        check_eq("stay_idle", {busy, gen_start}, 2'b00);
    endtask

    // call just after gen_start has been seen high
    task automatic run_packet(input int lat, input int blen, input bit fin, input bit drop);
        int gi, hi, e;
        bit got_ack, got_done;
        logic [32:0] latched;
        gi = rr_pick(s_req, m_last);
        check_eq("grant_valid", gi >= 0, 1'b1);
        if (gi < 0) return;
        check_eq("grant_index", grant_index, gi);
        check_eq("busy_start", busy, 1'b1);
        latched = {s_mac_enable[gi], s_node[gi*8 +: 8], s_type[gi*8 +: 8], s_length[gi*16 +: 16]};
        check_eq("gen_params", {gen_mac_enable, gen_node, gen_type, gen_length}, latched);
        m_last = gi;
        if (drop) s_req[gi] = 1'b0;

        hi = 1;
        got_ack = 1'b0;
        for (int t = 0; t < 200; t++) begin
            if (hi == lat) gen_busy = 1'b1;
            tick();
            if (s_ack != '0) begin
                got_ack = 1'b1;
                break;
            end
            if (en) hi++;
        end
        if (!got_ack) begin
            check_eq("ack_timeout", 0, 1);
            gen_busy = 1'b0;
            return;
        end
        check_eq("start_len", hi, lat);
        check_eq("ack_onehot", s_ack, N'(1) << gi);
        check_eq("start_low", gen_start, 1'b0);
        next_requests();
        scramble_params();

        e = 0;
        got_done = 1'b0;
        for (int t = 0; t < 4 * TB_TIMEOUT + 200; t++) begin
            if (fin && e >= blen) gen_finish = 1'b1;
            tick();
            if (en) begin
                e++;
                if (e == 1) check_eq("ack_pulse", s_ack, '0);
            end
            if (s_done != '0) begin
                got_done = 1'b1;
                break;
            end
        end
        gen_finish = 1'b0;
        gen_busy   = 1'b0;
        if (!got_done) begin
            check_eq("done_timeout", 0, 1);
            return;
        end
        check_eq("done_onehot", s_done, N'(1) << gi);
        if (fin) begin
            check_eq("done_lat", e, blen + 1);
        end else begin
            check_eq("wd_len", e, TB_TIMEOUT);
            m_timeout = 1'b1;
        end
        check_eq("timeout_flag", timeout_error, m_timeout);
        check_eq("param_hold", {gen_mac_enable, gen_node, gen_type, gen_length}, latched);
        check_eq("grant_hold", grant_index, gi);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        bit found;
        reset_n    = 1'b0;
        cke        = 1'b1;
        cke_rand   = 1'b0;
        s_req      = '0;
        gen_busy   = 1'b0;
        gen_finish = 1'b0;
        m_last     = N - 1;
        m_timeout  = 1'b0;
        req_mode   = 2;
        scramble_params();
        repeat (3) tick();
        check_eq("reset_state",
                 {gen_start, s_ack, s_done, busy, grant_index, gen_mac_enable,
                  gen_node, gen_type, gen_length, timeout_error}, '0);
        @(negedge clk) reset_n = 1'b1;

        // single requester, generator answers after two cycles
        s_req = 4'b0001;
        req_mode = 2;
        wait_start(1'b0, found);
        if (found) run_packet(2, 3, 1'b1, 1'b0);
        wait_idle();

        // all requesters held high: strict rotation
        s_req = '1;
        req_mode = 0;
        for (int k = 0; k < 5; k++) begin
            if (k == 4) req_mode = 2;
            wait_start(k > 0, found);
            if (!found) break;
            run_packet($urandom_range(1, 4), $urandom_range(1, 6), 1'b1, 1'b0);
        end
        wait_idle();

        // random traffic, second half with cke toggling
        s_req = N'($urandom) | 4'b0010;
        req_mode = 1;
        for (int k = 0; k < 24; k++) begin
            cke_rand = (k >= 12);
            if (k == 23) req_mode = 2;
            wait_start(k > 0, found);
            if (!found) break;
            run_packet($urandom_range(1, 4), $urandom_range(1, 6), 1'b1,
                       $urandom_range(0, 3) == 0);
        end
        wait_idle();
        cke_rand = 1'b0;

`ifdef JELLY2_NECOLINK_SCHEDULER_TIMEOUT_EN
        // generator never finishes: watchdog completes the packet
        s_req = 4'b1000;
        req_mode = 2;
        wait_start(1'b0, found);
        if (found) run_packet(1, 1, 1'b0, 1'b0);
        wait_idle();
`endif

        // reset while requester 2 is in WAIT_FINISH
        s_req = 4'b0100;
        scramble_params();
        wait_start(1'b0, found);
        check_eq("rst_grant", grant_index, 4'd2);
        gen_busy = 1'b1;
        for (int t = 0; t < 20 && s_ack == '0; t++) tick();
        check_eq("rst_ack", s_ack, 4'b0100);
        tick();
        tick();
        #2 reset_n = 1'b0;
        #1;
        check_eq("async_reset",
                 {gen_start, s_ack, s_done, busy, grant_index, gen_mac_enable,
                  gen_node, gen_type, gen_length, timeout_error}, '0);
        gen_busy  = 1'b0;
        s_req     = 4'b1110;
        m_last    = N - 1;
        m_timeout = 1'b0;
        tick();
        tick();
        check_eq("rst_no_done", s_done, '0);
        @(negedge clk) reset_n = 1'b1;
        req_mode = 2;
        wait_start(1'b0, found);
        check_eq("first_after_reset", grant_index, 4'd1);
        if (found) run_packet(1, 2, 1'b1, 1'b0);
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
